// File: rtl/rv32i_ctrl_pkg.sv
// Shared constants for the multicycle RV32I controller and ALU.
// Holds state codes, opcodes, ALUOp, AluControl and mux select encodings.
package rv32i_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BEQ      = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_HALT     = 4'd11;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXECUTER = ST_EXECUTER,
        S_EXECUTEI = ST_EXECUTEI,
        S_ALUWB    = ST_ALUWB,
        S_BEQ      = ST_BEQ,
        S_JAL      = ST_JAL,
        S_HALT     = ST_HALT
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp/funct3/funct7b5/op5 to the 3-bit AluControl.
// Ports: alu_op_i, funct3_i, funct7b5_i, op5_i in; alu_control_o out.
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // op5 separates R-type sub from addi with imm[10] set
                    3'b000:  alu_control_o = (funct7b5_i & op5_i) ? ALU_SUB
                                                                  : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b101:  alu_control_o = ALU_SRL;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default:   alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM driving datapath selects/enables.
// Ports: clk, reset, op, funct3, funct7b5, Zero in; PCWrite, AdrSrc,
// MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegWrite,
// AluControl out. Macro MULTICYCLE_CTRL_ILLEGAL_EN adds IllegalInstr/HALT.
module multicycle_controller
    import rv32i_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
    output logic       IllegalInstr,
`endif
    output logic [2:0] AluControl
);

    state_e     state_q;
    state_e     state_d;
    state_e     st;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset presents FETCH decode; write enables are gated separately below.
    assign st = reset ? S_FETCH : state_q;

    always_comb begin
        AdrSrc    = ADR_PC;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;
        branch    = 1'b0;
        pc_update = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        case (st)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = ADR_RESULT;
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = ADR_RESULT;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = ~reset & (pc_update | (branch & Zero) | (st == S_FETCH));
    assign MemWrite = ~reset & mem_write;
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_write;
    assign ImmSrc   = imm_src(op);

`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
    assign IllegalInstr = (st == S_HALT);
`endif

    alu_decoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (AluControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Walks each instruction class cycle by cycle against hand-written vectors.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [2:0] AluControl;
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
    logic       IllegalInstr;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] outv;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
        .IllegalInstr (IllegalInstr),
`endif
        .AluControl (AluControl)
    );

    assign outv = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, RegWrite, AluControl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Field packer only: {pcw,adr,mw,irw,rs,sa,sb,imm,rw,alu}
    function automatic logic [15:0] v(input logic pcw, input logic adr,
        input logic mw, input logic irw, input logic [1:0] rs,
        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
        input logic rw, input logic [2:0] alu);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu};
    endfunction

    task automatic set_ins(input logic [31:0] ins);
        op       = ins[6:0];
        funct3   = ins[14:12];
        funct7b5 = ins[30];
        #1;
    endtask

    task automatic step(input string tag, input logic [15:0] exp);
        check(tag, outv, exp);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_ins [7];
    logic [2:0]  r_alu [7];

    initial begin
        r_ins = '{32'h0020C1B3, 32'h0020A1B3, 32'h0020F1B3, 32'h002091B3,
                  32'h0020D1B3, 32'h0020B1B3, 32'h0020E1B3};
        r_alu = '{3'b100, 3'b101, 3'b010, 3'b110, 3'b111, 3'b000, 3'b011};

        reset = 1'b1;
        Zero  = 1'b1;
        set_ins(32'h00000033);

        // reset: FETCH decode, all write enables low
        step("rst0", v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("rst1", v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        reset = 1'b0;
        #1;

        // add x3,x1,x2
        set_ins(32'h002081B3);
        step("add_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("add_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
        step("add_ex", v(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b000));
        step("add_wb", v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000));

        // sub
        set_ins(32'h402081B3);
        step("sub_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("sub_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
        step("sub_ex", v(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b001));
        step("sub_wb", v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000));

        // other R-type funct3 codes
        for (int i = 0; i < 7; i++) begin
            set_ins(r_ins[i]);
            step("r_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
            step("r_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
            step("r_ex", v(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,r_alu[i]));
            step("r_wb", v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000));
        end

        // addi with imm bit 30 set: op5=0 keeps it ADD
        set_ins(32'h40008093);
        step("addi_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("addi_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
        step("addi_ex", v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000));
        step("addi_wb", v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000));

        // ori x1,x1,6
        set_ins(32'h0060E093);
        step("ori_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("ori_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
        step("ori_ex", v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b011));
        step("ori_wb", v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000));

        // lw x5,4(x1)
        set_ins(32'h0040A283);
        step("lw_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("lw_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
        step("lw_ma", v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000));
        step("lw_mr", v(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000));
        step("lw_wb", v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000));

        // sw
        set_ins(32'h0050A223);
        step("sw_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b000));
        step("sw_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b000));
        step("sw_ma", v(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000));
        step("sw_mw", v(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000));

        // beq taken
        set_ins(32'h00208463);
        step("beqt_f", v(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000));
        step("beqt_d", v(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000));
        step("beqt_b", v(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001));

        // beq not taken
        Zero = 1'b0;
        #1;
        step("beqn_f", v(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000));
        step("beqn_d", v(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000));
        step("beqn_b", v(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001));
        Zero = 1'b1;

        // jal
        set_ins(32'h008000EF);
        step("jal_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,3'b000));
        step("jal_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b11,0,3'b000));
        step("jal_j",  v(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b000));
        step("jal_wb", v(0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,3'b000));

        // lw interrupted by reset in MEMREAD
        set_ins(32'h0040A283);
        step("lwr_f",  v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("lwr_d",  v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
        step("lwr_ma", v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000));
        reset = 1'b1;
        #1;
        step("lwr_rs", v(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        reset = 1'b0;
        #1;
        step("lwr_f2", v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("lwr_d2", v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));

        // finish the restarted lw so the next instruction starts in FETCH
        step("lwr_ma2", v(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b000));
        step("lwr_mr2", v(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000));
        step("lwr_wb2", v(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b000));

        // unknown opcode
        set_ins(32'h0000007F);
        step("ill_f", v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("ill_d", v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
        for (int i = 0; i < 3; i++) begin
            check("halt_ill", {15'd0, IllegalInstr}, 16'd1);
            step("halt", v(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b000));
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("halt_clr", {15'd0, IllegalInstr}, 16'd0);
        step("halt_f", v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
`else
        step("ill_f2", v(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000));
        step("ill_d2", v(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
